cic_interpolator: RTL and testbench

CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

---
 rtl/cic_pkg.sv | 16 +
 rtl/cic_integrator_stage.sv | 17 +
 rtl/cic_interpolator.sv | 56 +++++
 tb/tb_cic_interpolator.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// cic_pkg: shared width helpers for the CIC interpolating and decimating filters.
package cic_pkg;

  function automatic int log2_f(input int v);
    int r;
    r = 0;
    for (int n = v; n > 1; n = n >> 1) r++;
    return r;
  endfunction

  // Each integrator after the first grows the word by log2(RATE) bits of gain.
  function automatic int out_width_f(input int w, input int s, input int r);
    return w + (s - 1) * log2_f(r);
  endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// cic_integrator_stage: enable-gated wrapping accumulator.
module cic_integrator_stage #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] acc_o
);
  logic [WIDTH-1:0] acc_q;
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else if (en_i) acc_q <= acc_q + din_i;
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC interpolator, combs at input rate, integrators at RATE x.
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STAGES    = 3,
  parameter int RATE      = 4,
  parameter int OUT_WIDTH = out_width_f(WIDTH, STAGES, RATE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid
);
  localparam int PW = log2_f(RATE);
  logic [PW-1:0] phase_q, phase_d;
  logic accept, en, out_valid_q;
  logic [OUT_WIDTH-1:0] c [STAGES+1];
  logic [OUT_WIDTH-1:0] d_q [STAGES];
  logic [OUT_WIDTH-1:0] ich [STAGES+1];
  assign in_ready = phase_q == '0;
  assign accept   = in_valid && in_ready;
  assign en       = accept || !in_ready;
  // RATE is a power of two, so the natural counter wrap gives RATE-1 -> 0.
  assign phase_d  = accept ? PW'(1) : in_ready ? phase_q : phase_q + PW'(1);
  always_comb begin
    c[0] = OUT_WIDTH'($signed(in_data));
    for (int k = 0; k < STAGES; k++) c[k+1] = c[k] - d_q[k];
  end
  assign ich[0] = accept ? c[STAGES] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
    end else begin
      phase_q     <= phase_d;
      out_valid_q <= en;
      if (accept) for (int k = 0; k < STAGES; k++) d_q[k] <= c[k];
    end
  end
  for (genvar i = 0; i < STAGES; i++) begin : g_int
    cic_integrator_stage #(.WIDTH(OUT_WIDTH)) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en_i (en),
      .din_i(ich[i]),
      .acc_o(ich[i+1])
    );
  end
  assign out_data  = ich[STAGES];
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed and randomised checks against the ideal CIC response.
module tb_cic_interpolator;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid;
  logic [11:0] out_data;
  int nchk = 0, nbad = 0, nv = 0;
  int got[$];
  int h[12] = '{0, 0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

  always #5 clk = ~clk;

  cic_interpolator dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    if (obs != exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int wrap12(input int v);
    logic [11:0] t;
    t = v[11:0];
    return int'($signed(t));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid) got.push_back(int'($signed(out_data)));
    else nv++;
  endtask

  task automatic send(input int s, output int w);
    in_data  = 8'(s);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 8) begin
      tick();
      w++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic flush();
    in_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    got.delete();
    nv = 0;
  endtask

  initial begin
    int w, bad, y;
    int s[$];
    do_reset();
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'($signed(out_data)), 0);
    check("rst_ready", int'(in_ready), 1);
    // reset lands mid-burst with a sample offered: it must win and leave nothing behind
    send(9, w);
    tick();
    check("burst_ready", int'(in_ready), 0);
    in_valid = 1'b1;
    in_data  = 8'd7;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_data", int'($signed(out_data)), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    got.delete();
    repeat (3) tick();
    check("mid_rst_quiet", got.size(), 0);

    got.delete();
    send(1, w);
    check("imp_wait0", w, 0);
    for (int i = 0; i < 5; i++) begin
      send(0, w);
      check($sformatf("imp_wait%0d", i + 1), w, 3);
    end
    flush();
    check("imp_len", got.size(), 24);
    for (int n = 0; n < 24; n++) check($sformatf("imp%0d", n), got[n], n < 12 ? h[n] : 0);

    do_reset();
    repeat (8) send(1, w);
    flush();
    check("dc_pos_len", got.size(), 32);
    check("dc_pos", got[31], 16);
    do_reset();
    repeat (8) send(-128, w);
    flush();
    check("dc_neg", got[31], -2048);

    do_reset();
    send(1, w);
    send(0, w);
    repeat (3) tick();
    check("stall_ready", int'(in_ready), 1);
    nv = 0;
    repeat (5) tick();
    send(0, w);
    check("stall_gap", nv, 5);
    repeat (3) send(0, w);
    flush();
    check("stall_len", got.size(), 24);
    for (int n = 0; n < 24; n++) check($sformatf("stall%0d", n), got[n], n < 12 ? h[n] : 0);

    do_reset();
    for (int i = 0; i < 1000; i++) begin
      int v;
      v = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      s.push_back(v);
      send(v, w);
    end
    flush();
    check("rand_len", got.size(), 4000);
    bad = 0;
    for (int n = 0; n < 4000; n++) begin
      y = 0;
      for (int m = 0; m < 12; m++)
        if (n - m >= 0 && (n - m) % 4 == 0) y += s[(n - m) / 4] * h[m];
      if (got[n] != wrap12(y)) bad++;
    end
    check("rand_bad", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nbad);
    $finish;
  end
endmodule
